// File: rtl/apb_master_bridge.sv
// APB master bridge: turns a valid/ready command into an APB SETUP/ACCESS transfer
// and returns read data and error status on a one-cycle response strobe.
module apb_master_bridge #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr
);

    // A zero TIMEOUT still needs a legal one-bit counter, which then never counts.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t                state_q, state_d;
    logic                  cmdReady_q, cmdReady_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  rspValid_q, rspValid_d;
    logic [DATA_WIDTH-1:0] rspRdata_q, rspRdata_d;
    logic                  rspErr_q, rspErr_d;
    logic [CW-1:0]         waitCnt_q, waitCnt_d;

    logic                  timedOut;

    assign timedOut = (TIMEOUT > 0) && (waitCnt_q == TIMEOUT_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmdReady_q <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pwrite_q   <= 1'b0;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
            waitCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cmdReady_q <= cmdReady_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pwrite_q   <= pwrite_d;
            rspValid_q <= rspValid_d;
            rspRdata_q <= rspRdata_d;
            rspErr_q   <= rspErr_d;
            waitCnt_q  <= waitCnt_d;
        end
    end

    // Next-state values are the values the registered outputs show in the following cycle.
    always_comb begin
        state_d    = state_q;
        cmdReady_d = cmdReady_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pwrite_d   = pwrite_q;
        rspValid_d = 1'b0;
        rspRdata_d = rspRdata_q;
        rspErr_d   = rspErr_q;
        waitCnt_d  = waitCnt_q;

        case (state_q)
            IDLE: begin
                cmdReady_d = 1'b1;
                psel_d     = 1'b0;
                penable_d  = 1'b0;
                if (cmd_valid && cmdReady_q) begin
                    state_d    = SETUP;
                    cmdReady_d = 1'b0;
                    psel_d     = 1'b1;
                    paddr_d    = cmd_addr;
                    pwdata_d   = cmd_wdata;
                    pwrite_d   = cmd_write;
                    waitCnt_d  = '0;
                end
            end

            SETUP: begin
                state_d    = ACCESS;
                cmdReady_d = 1'b0;
                psel_d     = 1'b1;
                penable_d  = 1'b1;
            end

            ACCESS: begin
                cmdReady_d = 1'b0;
                psel_d     = 1'b1;
                penable_d  = 1'b1;
                // A ready slave wins over the timeout even on the final allowed edge.
                if (pready) begin
                    state_d    = IDLE;
                    cmdReady_d = 1'b1;
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                    rspValid_d = 1'b1;
                    rspErr_d   = pslverr;
                    rspRdata_d = pwrite_q ? '0 : prdata;
                end else if (timedOut) begin
                    state_d    = IDLE;
                    cmdReady_d = 1'b1;
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                    rspValid_d = 1'b1;
                    rspErr_d   = 1'b1;
                    rspRdata_d = '0;
                end else if (TIMEOUT > 0) begin
                    waitCnt_d = waitCnt_q + CW'(1);
                end
            end

            default: begin
                state_d    = IDLE;
                cmdReady_d = 1'b0;
                psel_d     = 1'b0;
                penable_d  = 1'b0;
            end
        endcase
    end

    assign cmd_ready = cmdReady_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pwrite    = pwrite_q;
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;
    assign rsp_err   = rspErr_q;

endmodule
